// File: rtl/ghash_tag_verifier.sv
// GCM GHASH over AAD/ciphertext blocks plus the length block, then tag = Y ^ E(K,J0) compared to the received tag.
// Digit-serial multiply: NB_DATA/NB_DIGIT cycles per block; o_ready is high only while waiting for the next block.
module ghash_tag_verifier #(
    parameter int NB_DATA  = 128,
    parameter int NB_DIGIT = 8
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_h_key,
    input  logic [63:0]        i_len_aad,
    input  logic [63:0]        i_len_c,
    input  logic [NB_DATA-1:0] i_tag_mask,
    input  logic [NB_DATA-1:0] i_tag,
    input  logic [NB_DATA-1:0] i_data_x,
    input  logic               i_valid,
    input  logic               i_last,
    output logic               o_ready,
    output logic               o_done,
    output logic               o_pass,
    output logic [NB_DATA-1:0] o_tag
);

    localparam int NCYC = NB_DATA / NB_DIGIT;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0]      CNT_LAST = CW'(NCYC - 1);
    localparam logic [NB_DATA-1:0] R_POLY   = {8'he1, {(NB_DATA-8){1'b0}}};

    typedef enum logic [1:0] {IDLE, WAIT_DATA, MULT, DONE} state_t;

    state_t             state, state_nxt;
    logic [NB_DATA-1:0] h_q, len_q, mask_q, tag_q;
    logic [NB_DATA-1:0] y_q, z_q, v_q, a_q;
    logic [NB_DATA-1:0] tag_out_q;
    logic               pass_q;
    logic               pending_len;
    logic               op_is_len;
    logic [CW-1:0]      cnt;
    logic [NB_DATA-1:0] z_step, v_step, len_in;
    logic               lens_zero, mult_last;

    assign len_in    = NB_DATA'({i_len_aad, i_len_c});
    assign lens_zero = (i_len_aad == 64'd0) && (i_len_c == 64'd0);
    assign mult_last = (state == MULT) && (cnt == CNT_LAST);

    // One digit of the shift-and-add multiply; the operand is consumed from its MSB end.
    always_comb begin
        z_step = z_q;
        v_step = v_q;
        for (int i = 0; i < NB_DIGIT; i++) begin
            if (a_q[NB_DATA-1-i]) begin
                z_step = z_step ^ v_step;
            end
            v_step = (v_step >> 1) ^ (v_step[0] ? R_POLY : '0);
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (i_start) begin
            state_nxt = lens_zero ? MULT : WAIT_DATA;
        end else begin
            case (state)
                IDLE:      state_nxt = IDLE;
                WAIT_DATA: if (i_valid) state_nxt = MULT;
                MULT: begin
                    if (cnt == CNT_LAST) begin
                        if (op_is_len)        state_nxt = DONE;
                        else if (pending_len) state_nxt = MULT;
                        else                  state_nxt = WAIT_DATA;
                    end
                end
                DONE:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready = (state == WAIT_DATA);
        o_done  = (state == DONE);
        o_pass  = pass_q;
        o_tag   = tag_out_q;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            h_q         <= '0;
            len_q       <= '0;
            mask_q      <= '0;
            tag_q       <= '0;
            y_q         <= '0;
            z_q         <= '0;
            v_q         <= '0;
            a_q         <= '0;
            tag_out_q   <= '0;
            pass_q      <= 1'b0;
            pending_len <= 1'b0;
            op_is_len   <= 1'b0;
            cnt         <= '0;
        end else if (i_start) begin
            // Start wins over any in-flight work or a same-cycle data block.
            h_q         <= i_h_key;
            len_q       <= len_in;
            mask_q      <= i_tag_mask;
            tag_q       <= i_tag;
            y_q         <= '0;
            z_q         <= '0;
            v_q         <= i_h_key;
            a_q         <= lens_zero ? len_in : '0;
            op_is_len   <= lens_zero;
            pending_len <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                WAIT_DATA: begin
                    if (i_valid) begin
                        a_q         <= y_q ^ i_data_x;
                        z_q         <= '0;
                        v_q         <= h_q;
                        cnt         <= '0;
                        pending_len <= i_last;
                        op_is_len   <= 1'b0;
                    end
                end
                MULT: begin
                    if (!mult_last) begin
                        z_q <= z_step;
                        v_q <= v_step;
                        a_q <= a_q << NB_DIGIT;
                        cnt <= cnt + CW'(1);
                    end else begin
                        y_q <= z_step;
                        cnt <= '0;
                        if (op_is_len) begin
                            tag_out_q <= z_step ^ mask_q;
                            pass_q    <= ((z_step ^ mask_q) == tag_q);
                        end else if (pending_len) begin
                            a_q         <= z_step ^ len_q;
                            z_q         <= '0;
                            v_q         <= h_q;
                            pending_len <= 1'b0;
                            op_is_len   <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
